// File: rtl/j2c_pkg.sv
// j2c_pkg: shared state encoding and constants for the two-wire serial slave.
package j2c_pkg;
    typedef enum logic {IDLE, RECEIVE} state_e;
    localparam int DEF_MESSAGE_LENGTH = 8;
    localparam logic BUS_IDLE = 1'b1;
endpackage

// File: rtl/j2c_slave_if.sv
// j2c_slave_if: serial lines in, parallel word and status out.
interface j2c_slave_if #(parameter int MESSAGE_LENGTH = j2c_pkg::DEF_MESSAGE_LENGTH);
    logic sda;
    logic scl;
    logic [MESSAGE_LENGTH-1:0] data_out;
    logic data_valid;
    logic busy;
    logic frame_error;
    modport slave(input sda, scl, output data_out, data_valid, busy, frame_error);
    modport master(output sda, scl, input data_out, data_valid, busy, frame_error);
endinterface

// File: rtl/j2c_line_sync.sv
// j2c_line_sync: reset-to-idle line synchroniser with a delay flop for edge detection.
module j2c_line_sync import j2c_pkg::*; #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic line_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic del_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{BUS_IDLE}};
            del_q  <= BUS_IDLE;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], line_i};
            del_q  <= sync_q[SYNC_STAGES-1];
        end
    end
    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = level_o & ~del_q;
    assign fall_o  = ~level_o & del_q;
endmodule

// File: rtl/j2c_slave.sv
// j2c_slave: oversampling two-wire slave shifting in LSB-first frames after a start condition.
module j2c_slave import j2c_pkg::*; #(
    parameter int MESSAGE_LENGTH = DEF_MESSAGE_LENGTH,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    j2c_slave_if.slave bus
);
    localparam int CW = $clog2(MESSAGE_LENGTH + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    logic sda_s, sda_rise, sda_fall, scl_s, scl_rise, scl_fall;
    logic start, stop;
    state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [MESSAGE_LENGTH-1:0] shift_q, shift_d, data_q, data_d;
    logic valid_q, valid_d, ferr_q, ferr_d, busy_q;

    j2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sda (
        .clk(clk), .rst(rst), .line_i(bus.sda), .level_o(sda_s), .rise_o(sda_rise), .fall_o(sda_fall)
    );
    j2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_scl (
        .clk(clk), .rst(rst), .line_i(bus.scl), .level_o(scl_s), .rise_o(scl_rise), .fall_o(scl_fall)
    );

    // scl high in both sync and delay stage; an sda change alongside an scl rise is data
    assign start = scl_s & ~scl_rise & sda_fall;
    assign stop  = scl_s & ~scl_rise & sda_rise;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        if (state_q == IDLE) begin
            if (start) begin
                state_d = RECEIVE;
                cnt_d   = '0;
                tmo_d   = '0;
                shift_d = '0;
            end
        end else if (start) begin
            ferr_d  = 1'b1;
            cnt_d   = '0;
            tmo_d   = '0;
            shift_d = '0;
        end else if (stop) begin
            ferr_d  = 1'b1;
            state_d = IDLE;
        end else if (scl_rise) begin
            shift_d = shift_q | (MESSAGE_LENGTH'(sda_s) << cnt_q);
            cnt_d   = cnt_q + 1'b1;
            tmo_d   = '0;
            if (cnt_q == CW'(MESSAGE_LENGTH - 1)) begin
                data_d  = shift_d;
                valid_d = 1'b1;
                state_d = IDLE;
            end
        end else if (scl_fall) begin
            tmo_d = '0;
        end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
            ferr_d  = 1'b1;
            state_d = IDLE;
        end else begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tmo_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            busy_q  <= (state_d == RECEIVE);
        end
    end

    assign bus.data_out    = data_q;
    assign bus.data_valid  = valid_q;
    assign bus.frame_error = ferr_q;
    assign bus.busy        = busy_q;
endmodule
